pdp11_instr_encoder: RTL and testbench

Converts a symbolic PDP-11 instruction request (mnemonic plus operand fields) into binary instruction words: the opcode word, then the source and destination extension words where needed. Each word goes out on a memory-write stream at consecutive word addresses. This is the write-side counterpart of the instruction-format decode. It serves as the bench/loader front end that builds memory images for the simulator.

---
 rtl/pdp11_instr_encoder_if.sv | 38 +++
 rtl/pdp11_instr_encoder.sv | 181 ++++++++++++++++++
 tb/tb_pdp11_instr_encoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pdp11_instr_encoder_if.sv
// Request and memory-write bus between a PDP-11 instruction encoder and its
// requester/sink.
//   master : the requester and write sink (drives req_*, addr_load*, wr_ready)
//   slave  : the encoder (drives req_ready, wr_*, err)
interface pdp11_instr_encoder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_mnem;
  logic [2:0]        req_smod;
  logic [2:0]        req_sreg;
  logic [2:0]        req_dmod;
  logic [2:0]        req_dreg;
  logic [7:0]        req_ofst;
  logic [15:0]       req_sext;
  logic [15:0]       req_dext;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_load_val;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_last;
  logic              err;

  modport master (
    output req_valid, req_mnem, req_smod, req_sreg, req_dmod, req_dreg, req_ofst,
    output req_sext, req_dext, addr_load, addr_load_val, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, wr_last, err
  );

  modport slave (
    input  req_valid, req_mnem, req_smod, req_sreg, req_dmod, req_dreg, req_ofst,
    input  req_sext, req_dext, addr_load, addr_load_val, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, wr_last, err
  );
endinterface

// File: rtl/pdp11_instr_encoder.sv
// Turns a symbolic PDP-11 instruction request into its binary words (opcode,
// then optional source and destination extension words) and streams them out
// at consecutive even byte addresses.
//   clk     : clock, posedge
//   reset_n : synchronous active-low reset
//   bus     : request in (req_*), write-address load (addr_load*),
//             word stream out (wr_*), one-cycle reject pulse (err)
// Mnemonic numbering of req_mnem (0-based):
//   MOV CMP BIT BIC BIS ADD MOVB CMPB BITB BICB BISB SUB            0..11
//   BR BNE BEQ BGE BLT BGT BLE BPL BMI BHI BLOS BVC BVS BCC BCS    12..26
//   CLR COM INC DEC NEG ADC SBC TST ROR ROL ASR ASL                27..38
//   the same twelve byte forms (CLRB..ASLB)                        39..50
//   JSR RTS JMP SWAB                                               51..54
//   HALT NOP CLC CLV CLZ CLN SEC SEV SEZ SEN                       55..64
module pdp11_instr_encoder #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'o001000
) (
  input logic                   clk,
  input logic                   reset_n,
  pdp11_instr_encoder_if.slave  bus
);

  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ResetAddr = BASE_ADDR & AlignMask;

  localparam logic [31:0] MnAdd  = 32'd5;
  localparam logic [31:0] MnSub  = 32'd11;
  localparam logic [31:0] MnBr   = 32'd12;
  localparam logic [31:0] MnBle  = 32'd18;
  localparam logic [31:0] MnBpl  = 32'd19;
  localparam logic [31:0] MnBcs  = 32'd26;
  localparam logic [31:0] MnClr  = 32'd27;
  localparam logic [31:0] MnAsl  = 32'd38;
  localparam logic [31:0] MnClrb = 32'd39;
  localparam logic [31:0] MnAslb = 32'd50;
  localparam logic [31:0] MnJsr  = 32'd51;
  localparam logic [31:0] MnRts  = 32'd52;
  localparam logic [31:0] MnJmp  = 32'd53;
  localparam logic [31:0] MnSwab = 32'd54;
  localparam logic [31:0] MnHalt = 32'd55;
  localparam logic [31:0] MnSen  = 32'd64;

  typedef enum logic [1:0] {StIdle, StOp, StSx, StDx} state_e;

  // Indexed/indirect modes, and immediate/absolute through the PC.
  function automatic logic need_ext(input logic [2:0] mode, input logic [2:0] rn);
    return (mode == 3'd6) || (mode == 3'd7) || ((rn == 3'd7) && ((mode == 3'd2) || (mode == 3'd3)));
  endfunction

  logic [31:0] mn;
  logic [5:0]  ss, dd;
  logic [15:0] op_word;
  logic        legal, src_ext, dst_ext;

  assign mn = bus.req_mnem;
  assign ss = {bus.req_smod, bus.req_sreg};
  assign dd = {bus.req_dmod, bus.req_dreg};

  always_comb begin
    op_word = '0;
    legal   = 1'b1;
    src_ext = 1'b0;
    dst_ext = 1'b0;
    if (mn <= MnSub) begin
      // Word forms map to 1..6, byte forms and SUB to 9..14.
      op_word = {((mn <= MnAdd) ? 4'(mn + 32'd1) : 4'(mn + 32'd3)), ss, dd};
      src_ext = need_ext(bus.req_smod, bus.req_sreg);
      dst_ext = need_ext(bus.req_dmod, bus.req_dreg);
    end else if (mn <= MnBle) begin
      op_word = 16'((mn - MnBr + 32'd1) << 8) | {8'h00, bus.req_ofst};
    end else if (mn <= MnBcs) begin
      op_word = 16'o100000 | 16'((mn - MnBpl) << 8) | {8'h00, bus.req_ofst};
    end else if (mn <= MnAsl) begin
      op_word = (16'o005000 + 16'((mn - MnClr) << 6)) | {10'b0, dd};
      dst_ext = need_ext(bus.req_dmod, bus.req_dreg);
    end else if (mn <= MnAslb) begin
      op_word = (16'o105000 + 16'((mn - MnClrb) << 6)) | {10'b0, dd};
      dst_ext = need_ext(bus.req_dmod, bus.req_dreg);
    end else if (mn == MnJsr) begin
      op_word = 16'o004000 | {7'b0, bus.req_sreg, dd};
      dst_ext = need_ext(bus.req_dmod, bus.req_dreg);
      legal   = (bus.req_dmod != 3'd0);
    end else if (mn == MnRts) begin
      op_word = 16'o000200 | {13'b0, bus.req_dreg};
    end else if (mn == MnJmp) begin
      op_word = 16'o000100 | {10'b0, dd};
      dst_ext = need_ext(bus.req_dmod, bus.req_dreg);
      legal   = (bus.req_dmod != 3'd0);
    end else if (mn == MnSwab) begin
      op_word = 16'o000300 | {10'b0, dd};
      dst_ext = need_ext(bus.req_dmod, bus.req_dreg);
    end else if (mn <= MnSen) begin
      case (4'(mn - MnHalt))
        4'd0:    op_word = 16'o000000;
        4'd1:    op_word = 16'o000240;
        4'd2:    op_word = 16'o000241;
        4'd3:    op_word = 16'o000242;
        4'd4:    op_word = 16'o000244;
        4'd5:    op_word = 16'o000250;
        4'd6:    op_word = 16'o000261;
        4'd7:    op_word = 16'o000262;
        4'd8:    op_word = 16'o000264;
        default: op_word = 16'o000270;
      endcase
    end else begin
      legal = 1'b0;
    end
  end

  state_e            state_q;
  logic              ready_q, valid_q, last_q, err_q, sx_q, dx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q, sext_q, dext_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      sx_q    <= 1'b0;
      dx_q    <= 1'b0;
      addr_q  <= ResetAddr;
      data_q  <= '0;
      sext_q  <= '0;
      dext_q  <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (bus.addr_load) addr_q <= bus.addr_load_val & AlignMask;
          if (bus.req_valid && ready_q) begin
            if (legal) begin
              state_q <= StOp;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              data_q  <= op_word;
              last_q  <= !(src_ext || dst_ext);
              sx_q    <= src_ext;
              dx_q    <= dst_ext;
              sext_q  <= bus.req_sext;
              dext_q  <= bus.req_dext;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StOp, StSx, StDx: begin
          if (bus.wr_ready) begin
            addr_q <= addr_q + ADDR_W'(2);
            if (state_q == StOp && sx_q) begin
              state_q <= StSx;
              data_q  <= sext_q;
              last_q  <= !dx_q;
            end else if (state_q != StDx && dx_q) begin
              state_q <= StDx;
              data_q  <= dext_q;
              last_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.wr_valid  = valid_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.wr_last   = last_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pdp11_instr_encoder.sv
module tb_pdp11_instr_encoder;

  localparam int MnMov = 0,  MnAdd = 5,  MnSub = 11, MnBr = 12, MnBne = 13, MnBpl = 19;
  localparam int MnBcs = 26, MnClr = 27, MnAsl = 38, MnIncb = 41, MnJsr = 51, MnRts = 52;
  localparam int MnJmp = 53, MnSwab = 54, MnNop = 56, MnSen = 64;

  typedef struct {
    int          mn;
    logic [2:0]  smod, sreg, dmod, dreg;
    logic [7:0]  ofst;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_addr;
  vec_t vecs[12];

  pdp11_instr_encoder_if #(.ADDR_W(16)) bus ();

  pdp11_instr_encoder #(.ADDR_W(16), .BASE_ADDR(16'o001000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %o, expected %o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int mn, input logic [2:0] smod, input logic [2:0] sreg,
                      input logic [2:0] dmod, input logic [2:0] dreg, input logic [7:0] ofst,
                      input logic [15:0] sext, input logic [15:0] dext);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("req_ready_before_send", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_mnem  = mn;
    bus.req_smod  = smod;
    bus.req_sreg  = sreg;
    bus.req_dmod  = dmod;
    bus.req_dreg  = dreg;
    bus.req_ofst  = ofst;
    bus.req_sext  = sext;
    bus.req_dext  = dext;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Waits (bounded) for a word, checks it, then lets it transfer.
  task automatic expect_word(input string tag, input logic [15:0] addr,
                             input logic [15:0] data, input logic last);
    int n = 0;
    while (!bus.wr_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, bus.wr_valid, 1);
    check_eq({tag, "_addr"}, bus.wr_addr, addr);
    check_eq({tag, "_data"}, bus.wr_data, data);
    check_eq({tag, "_last"}, bus.wr_last, last);
    tick();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mnem = '0;
    bus.req_smod = '0;
    bus.req_sreg = '0;
    bus.req_dmod = '0;
    bus.req_dreg = '0;
    bus.req_ofst = '0;
    bus.req_sext = '0;
    bus.req_dext = '0;
    bus.addr_load = 1'b0;
    bus.addr_load_val = '0;
    bus.wr_ready = 1'b1;

    vecs[0]  = '{MnBne,  0, 0, 0, 0, 8'hFD, 16'o001375};
    vecs[1]  = '{MnBr,   0, 0, 0, 0, 8'h7F, 16'o000577};
    vecs[2]  = '{MnSen,  0, 0, 0, 0, 8'h00, 16'o000270};
    vecs[3]  = '{MnRts,  0, 0, 0, 7, 8'h00, 16'o000207};
    vecs[4]  = '{MnIncb, 0, 0, 0, 4, 8'h00, 16'o105204};
    vecs[5]  = '{MnAsl,  0, 0, 0, 1, 8'h00, 16'o006301};
    vecs[6]  = '{MnSwab, 0, 0, 0, 0, 8'h00, 16'o000300};
    vecs[7]  = '{MnJsr,  0, 5, 1, 2, 8'h00, 16'o004512};
    vecs[8]  = '{MnSub,  0, 2, 0, 3, 8'h00, 16'o160203};
    vecs[9]  = '{MnBpl,  0, 0, 0, 0, 8'h80, 16'o100200};
    vecs[10] = '{MnBcs,  0, 0, 0, 0, 8'h01, 16'o103401};
    vecs[11] = '{MnNop,  0, 0, 0, 0, 8'h00, 16'o000240};

    // Reset state
    tick();
    tick();
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_wr_valid", bus.wr_valid, 0);
    check_eq("rst_wr_last", bus.wr_last, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_wr_data", bus.wr_data, 16'o000000);
    check_eq("rst_wr_addr", bus.wr_addr, 16'o001000);
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("post_rst_req_ready", bus.req_ready, 1);

    // MOV R1,R2: single word
    send(MnMov, 0, 1, 0, 2, 8'h00, 16'h0, 16'h0);
    expect_word("mov", 16'o001000, 16'o010102, 1'b1);
    check_eq("mov_ready_after", bus.req_ready, 1);
    check_eq("mov_valid_after", bus.wr_valid, 0);

    // ADD #5,4(R3) with the source extension word stalled for 3 cycles
    send(MnAdd, 2, 7, 6, 3, 8'h00, 16'o000005, 16'o000004);
    expect_word("add_op", 16'o001002, 16'o062763, 1'b0);
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_valid", bus.wr_valid, 1);
      check_eq("stall_data", bus.wr_data, 16'o000005);
      check_eq("stall_addr", bus.wr_addr, 16'o001004);
    end
    bus.wr_ready = 1'b1;
    expect_word("add_sx", 16'o001004, 16'o000005, 1'b0);
    expect_word("add_dx", 16'o001006, 16'o000004, 1'b1);
    check_eq("add_ready_after", bus.req_ready, 1);

    // Single-word encodings
    exp_addr = 16'o001010;
    foreach (vecs[i]) begin
      send(vecs[i].mn, vecs[i].smod, vecs[i].sreg, vecs[i].dmod, vecs[i].dreg, vecs[i].ofst,
           16'h0, 16'h0);
      expect_word($sformatf("vec%0d", i), exp_addr, vecs[i].exp, 1'b1);
      exp_addr = exp_addr + 16'd2;
    end

    // Illegal: JMP R0
    send(MnJmp, 0, 0, 0, 0, 8'h00, 16'h0, 16'h0);
    check_eq("jmp_err", bus.err, 1);
    check_eq("jmp_no_valid", bus.wr_valid, 0);
    tick();
    check_eq("jmp_err_pulse", bus.err, 0);
    check_eq("jmp_no_valid2", bus.wr_valid, 0);
    check_eq("jmp_addr_same", bus.wr_addr, exp_addr);

    // Address load (odd value, bit 0 dropped) and wrap
    bus.addr_load = 1'b1;
    bus.addr_load_val = 16'o177777;
    tick();
    bus.addr_load = 1'b0;
    check_eq("aload_addr", bus.wr_addr, 16'o177776);
    send(MnClr, 0, 0, 3, 7, 8'h00, 16'h0, 16'o002000);
    expect_word("clr_op", 16'o177776, 16'o005037, 1'b0);
    expect_word("clr_dx", 16'o000000, 16'o002000, 1'b1);

    // Reset while the destination extension word is pending
    send(MnMov, 0, 1, 6, 2, 8'h00, 16'h0, 16'o000006);
    expect_word("movx_op", 16'o000002, 16'o010162, 1'b0);
    check_eq("movx_in_dx", bus.wr_data, 16'o000006);
    reset_n = 1'b0;
    tick();
    check_eq("mid_rst_valid", bus.wr_valid, 0);
    check_eq("mid_rst_addr", bus.wr_addr, 16'o001000);
    check_eq("mid_rst_ready", bus.req_ready, 0);
    reset_n = 1'b1;
    send(MnMov, 0, 1, 0, 2, 8'h00, 16'h0, 16'h0);
    expect_word("mov_after_rst", 16'o001000, 16'o010102, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
